// File: rtl/swd_xact.sv
// swd_xact: SWD transaction encoder/decoder sitting in front of the SWD PHY.
// Packs DP/AP read/write and line-reset requests into PHY command words
// {LEN, T0, T1, SO}, tracks responding commands in order, and decodes the
// PHY's {SI, ILEN} words into ACK / read data / parity status.
// Build option: define SWD_XACT_PARITY_CHK_EN to build the read-data parity
// check; without it RESP_PERR is always 0.
module swd_xact #(
  parameter  int OWIDTH = 64,
  parameter  int IWIDTH = 38,
  parameter  int TAGS   = 8,
  localparam int LW     = $clog2(OWIDTH),
  localparam int ILW    = $clog2(IWIDTH)
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic                   REQ_LRST,
  input  logic                   REQ_APNDP,
  input  logic                   REQ_RNW,
  input  logic [1:0]             REQ_ADDR,
  input  logic [31:0]            REQ_WDATA,
  output logic                   RESP_VALID,
  input  logic                   RESP_READY,
  output logic                   RESP_RNW,
  output logic [2:0]             RESP_ACK,
  output logic [31:0]            RESP_RDATA,
  output logic                   RESP_PERR,
  output logic [OWIDTH+3*LW-1:0] PHY_WRDATA,
  output logic                   PHY_WREN,
  input  logic                   PHY_WRFULL,
  input  logic [IWIDTH-2+ILW:0]  PHY_RDDATA,
  output logic                   PHY_RDEN,
  input  logic                   PHY_RDEMPTY
);

  localparam int            TW       = $clog2(TAGS);
  localparam logic [TW:0]   CNT_ONE  = (TW+1)'(1);
  localparam logic [TW:0]   CNT_FULL = (TW+1)'(TAGS);
  localparam logic [TW-1:0] PTR_ONE  = TW'(1);

  logic                   cmd_v;
  logic [OWIDTH+3*LW-1:0] cmd;
  logic [LW-1:0]          enc_len, enc_t0, enc_t1;
  logic [OWIDTH-1:0]      enc_so;
  logic                   req_par;
  logic                   tags_full, accept, tag_push, tag_pop;
  logic [TAGS-1:0]        tag_rnw;
  logic [TW-1:0]          tag_wp, tag_rp;
  logic [TW:0]            tag_cnt;
  logic                   head_rnw;
  logic                   rd_pend;
  logic [IWIDTH-2:0]      si;
  logic [ILW-1:0]         ilen;
  logic [2:0]             dec_ack;
  logic [31:0]            dec_rdata;
  logic                   dec_perr;

  // Line resets never produce a response, so only responding requests are
  // held back by a full tag FIFO.
  assign tags_full  = (tag_cnt == CNT_FULL);
  assign REQ_READY  = RESETn & (~cmd_v | ~PHY_WRFULL) & (REQ_LRST | ~tags_full);
  assign accept     = REQ_VALID & REQ_READY;
  assign tag_push   = accept & ~REQ_LRST;
  assign tag_pop    = rd_pend;
  assign PHY_WREN   = cmd_v & ~PHY_WRFULL;
  assign PHY_WRDATA = cmd;
  assign PHY_RDEN   = ~PHY_RDEMPTY & (tag_cnt != '0) & ~rd_pend & (~RESP_VALID | RESP_READY);

  assign head_rnw = tag_rnw[tag_rp];
  assign si       = PHY_RDDATA[IWIDTH-2+ILW:ILW];
  assign ilen     = PHY_RDDATA[ILW-1:0];

  // Encode the incoming request into the PHY command word (SO is sent LSB-first).
  always_comb begin
    req_par = REQ_APNDP ^ REQ_RNW ^ REQ_ADDR[0] ^ REQ_ADDR[1];
    enc_so  = '0;
    enc_len = LW'(46);
    enc_t0  = LW'(8);
    enc_t1  = LW'(45);
    if (REQ_LRST) begin
      enc_so[51:0] = '1;
      enc_len      = LW'(60);
      enc_t0       = LW'(63);
      enc_t1       = LW'(63);
    end else begin
      enc_so[7:0] = {1'b1, 1'b0, req_par, REQ_ADDR[1], REQ_ADDR[0], REQ_RNW, REQ_APNDP, 1'b1};
      if (!REQ_RNW) begin
        enc_t1        = LW'(13);
        enc_so[44:13] = REQ_WDATA;
        enc_so[45]    = ^REQ_WDATA;
      end
    end
  end

  // Issue register: load on accept, clear once the PHY FIFO takes it.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cmd_v <= 1'b0;
      cmd   <= '0;
    end else if (accept) begin
      cmd_v <= 1'b1;
      cmd   <= {enc_len, enc_t0, enc_t1, enc_so};
    end else if (PHY_WREN) begin
      cmd_v <= 1'b0;
    end
  end

  // In-order tag FIFO holding RnW of every outstanding responding command.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tag_rnw <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) begin
        tag_rnw[tag_wp] <= REQ_RNW;
        tag_wp          <= tag_wp + PTR_ONE;
      end
      if (tag_pop) tag_rp <= tag_rp + PTR_ONE;
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_ONE;
        2'b01:   tag_cnt <= tag_cnt - CNT_ONE;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Decode the received bits; the k-th bit on the wire sits at SI[ILEN-1-k].
  always_comb begin
    dec_ack   = 3'b111;
    dec_rdata = '0;
    dec_perr  = 1'b0;
    if (!head_rnw && ilen == ILW'(3)) begin
      dec_ack = {si[0], si[1], si[2]};
    end else if (head_rnw && ilen == ILW'(36)) begin
      dec_ack = {si[33], si[34], si[35]};
      for (int j = 0; j < 32; j++) dec_rdata[j] = si[32-j];
`ifdef SWD_XACT_PARITY_CHK_EN
      dec_perr = si[0] ^ (^dec_rdata);
`endif
    end
  end

`ifndef SWD_XACT_PARITY_CHK_EN
  logic unused_par_bit;
  assign unused_par_bit = si[0];
`endif
  logic unused_si_top;
  assign unused_si_top = si[IWIDTH-2];

  // Response register: capture the PHY word one cycle after the read strobe.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd_pend    <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_RNW   <= 1'b0;
      RESP_ACK   <= 3'b000;
      RESP_RDATA <= '0;
      RESP_PERR  <= 1'b0;
    end else begin
      rd_pend <= PHY_RDEN;
      if (rd_pend) begin
        RESP_VALID <= 1'b1;
        RESP_RNW   <= head_rnw;
        RESP_ACK   <= dec_ack;
        RESP_RDATA <= dec_rdata;
        RESP_PERR  <= dec_perr;
      end else if (RESP_READY) begin
        RESP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/swd_xact.md
# swd_xact

SWD transaction encoder/decoder. It sits directly upstream of the SWD PHY. It accepts ADIv5 DP/AP read/write and line-reset requests, packs each into a PHY command word `{LEN, T0, T1, SO}`, and tracks outstanding commands in order. It decodes the PHY's returned `{SI, ILEN}` words into ACK, read data and parity status. Everything runs in the interface (CLK) domain; the PHY's dual-clock FIFOs handle the crossing.

## Interface
- `OWIDTH`, 64: PHY shift-out width. LW = $clog2(OWIDTH) = 6.
- `IWIDTH`, 38: PHY shift-in width. ILW = $clog2(IWIDTH) = 6.
- `TAGS`, 8: max outstanding responding commands (power of 2).
- `CLK`  in  1  interface clock.
- `RESETn`  in  1  reset; asynchronous, active-low.
- `REQ_VALID`  in  1  request valid.
- `REQ_READY`  out  1  request accepted when VALID&READY.
- `REQ_LRST`  in  1  line reset (other REQ_* ignored).
- `REQ_APNDP`  in  1  1 = AP, 0 = DP.
- `REQ_RNW`  in  1  1 = read.
- `REQ_ADDR`  in  2  A[3:2].
- `REQ_WDATA`  in  32  write data.
- `RESP_VALID`  out  1  response valid.
- `RESP_READY`  in  1  response consumed when VALID&READY.
- `RESP_RNW`  out  1  echo of the request type.
- `RESP_ACK`  out  3  SWD ACK, wire order {bit2,bit1,bit0}; 3'b111 on length error.
- `RESP_RDATA`  out  32  read data (0 for writes).
- `RESP_PERR`  out  1  read data parity error.
- `PHY_WRDATA`  out  OWIDTH+3*LW  `{LEN, T0, T1, SO}`.
- `PHY_WREN`  out  1  PHY command FIFO write.
- `PHY_WRFULL`  in  1  PHY command FIFO full.
- `PHY_RDDATA`  in  IWIDTH-1+ILW  `{SI[IWIDTH-2:0], ILEN}`.
- `PHY_RDEN`  out  1  PHY response FIFO read.
- `PHY_RDEMPTY`  in  1  PHY response FIFO empty.

## Operation
- `SO` is transmitted LSB-first.
  - Request byte, bits 0..7: 1, APnDP, RnW, A2, A3, P = APnDP^RnW^A2^A3, 0, 1.
- T0 is the index of the first host-released bit; T1 is the index of the first re-driven bit.
- Read: LEN=46, T0=8, T1=45. SO[63:8]=0.
- Write: LEN=46, T0=8, T1=13. SO[44:13]=WDATA, SO[45]=^WDATA, all other SO bits above 7 are 0.
- Line reset: LEN=60, T0=T1=63 (never reached). SO[51:0] all ones, SO[63:52]=0. No response is expected.
- Issue stage is a single register `cmd`.
  - Accept: REQ_READY = !cmd_v || (!PHY_WRFULL), and tag count < TAGS (the tag check applies only to responding requests). On accept, `cmd` loads the encoded word.
  - Drain: PHY_WREN = cmd_v & !PHY_WRFULL.
- Tag FIFO (depth TAGS): RnW is pushed on accept of every non-LRST request and popped when a PHY response is captured. Responses are strictly in order.
- Response stage: a one-entry output register.
  - PHY_RDEN = !PHY_RDEMPTY & tag non-empty & (!rd_pend) & (!RESP_VALID | RESP_READY).
  - PHY_RDDATA is sampled the cycle after PHY_RDEN (rd_pend flag). That sample loads the output register and sets RESP_VALID.
- Decode, with n = ILEN: the k-th received bit is SI[n-1-k].
  - Write, n=3: ACK[i]=SI[2-i].
  - Read, n=36: ACK[i]=SI[35-i]; RDATA[j]=SI[32-j]; parity bit SI[0]; PERR = SI[0] ^ (^RDATA).
  - Any other n: ACK=3'b111, RDATA=0, PERR=0. The tag is still popped.
- ACK values are reported only; this block takes no action on WAIT/FAULT.

## Timing
- Reset values: REQ_READY=0 while RESETn is low, PHY_WREN=0, PHY_RDEN=0, RESP_VALID=0, RESP_ACK=0, RESP_RDATA=0, RESP_PERR=0, RESP_RNW=0. Tag FIFO empty, cmd_v=0.
- REQ accept -> PHY_WREN: 1 cycle, if not full.
- Back-to-back accepts: one per cycle while PHY_WRFULL=0.
- PHY_RDEN -> RESP_VALID: 2 cycles.
- RESP_VALID holds, with data stable, until RESP_READY.
- Simultaneous tag push and pop: count unchanged.
- A tag at TAGS blocks only responding requests; LRST is still accepted.
- PHY_WRFULL while cmd_v: `cmd` holds, REQ_READY=0.
- Reset mid-operation clears all state immediately. Responses still in the PHY are the system's responsibility (the PHY is reset together with this block).

## Configuration
- `SWD_XACT_PARITY_CHK_EN` defined: RESP_PERR is computed as above.
- Not defined: the parity XOR is not built and RESP_PERR is tied 0.

## Test plan
- DP read, ADDR=0 (IDCODE) -> PHY_WRDATA SO[7:0]=0xA5, LEN=46, T0=8, T1=45. Return ILEN=36 with ACK=001 and data 0x2BA01477 -> RESP_ACK=3'b001, RDATA=0x2BA01477, PERR=0.
- DP write, ADDR=2'b10 (SELECT), WDATA=0x000000F0 -> SO[7:0]=0xB1, SO[44:13]=0xF0, SO[45]=0, T1=13. ILEN=3 ACK=001 -> RESP_ACK=001, RNW=0.
- Line reset -> LEN=60, SO[51:0]=all ones, no tag push. A following read response maps to that read.
- 9 reads with PHY_RDEMPTY held high -> 8 accepted, REQ_READY low on the 9th. After one response is consumed, the 9th is accepted.
- Read response with a flipped parity bit -> PERR=1 with the macro defined, 0 without. ILEN=5 -> ACK=3'b111.
- PHY_WRFULL held for 10 cycles and RESP_READY low -> no PHY_WREN, `cmd` stable, RESP_VALID held. Release -> in-order completion.
